// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_arbiter (with combinational fp_adder)
// Brief    : Round-robin sharing of one single-precision adder between up
//            to eight requesters, two registered stages, tagged responses.
// Revision : 1.0
// ============================================================================

module fp_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic [31:0] x, y;
    logic [7:0]  xe, ye, dexp;
    logic [23:0] xm, ym;
    logic [26:0] ys, mask;
    logic [27:0] acc;
    logic [9:0]  e;
    logic [24:0] mant;
    logic        rnd;

    always_comb begin
        mask = '0;
        // x is always the larger magnitude, so its sign wins and the subtract never goes negative
        if (b[30:0] > a[30:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        xe   = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ye   = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        xm   = {x[30:23] != 8'd0, x[22:0]};
        ym   = {y[30:23] != 8'd0, y[22:0]};
        dexp = xe - ye;
        if (dexp > 8'd26) begin
            ys = {26'd0, |ym};
        end else begin
            mask = (27'd1 << dexp) - 27'd1;
            ys   = ({ym, 3'b000} >> dexp) | {26'd0, |({ym, 3'b000} & mask)};
        end
        acc = (x[31] == y[31]) ? ({1'b0, xm, 3'b000} + {1'b0, ys})
                               : ({1'b0, xm, 3'b000} - {1'b0, ys});
        e = {2'b00, xe};
        if (acc[27]) begin
            acc = {1'b0, acc[27:2], acc[1] | acc[0]};
            e   = e + 10'd1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!acc[26] && e > 10'd1) begin
                acc = acc << 1;
                e   = e - 10'd1;
            end
        end
        rnd  = acc[2] & (acc[1] | acc[0] | acc[3]);
        mant = {1'b0, acc[26:3]} + {24'd0, rnd};
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 10'd1;
        end
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] != 23'd0)
                sum = x | 32'h0040_0000;
            else if (y[30:23] == 8'hFF && x[31] != y[31])
                sum = 32'h7FC0_0000;
            else
                sum = x;
        end else if (e >= 10'd255) begin
            sum = {x[31], 8'hFF, 23'd0};
        end else if (mant[23:0] == 24'd0) begin
            sum = {x[31] & y[31], 31'd0};
        end else begin
            sum = {x[31], mant[23] ? e[7:0] : 8'd0, mant[22:0]};
        end
    end
endmodule

module fp_add_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_data,
    output logic                  busy,
    output logic [31:0]           ops_done
);
    logic            s1_valid;
    logic [ID_W-1:0] s1_id;
    logic [31:0]     s1_a, s1_b, sum;
    logic [ID_W-1:0] rr_ptr, win_id;
    logic [ID_W:0]   idx;
    logic            found, s2_free, s1_load, s1_adv, accept;

    fp_adder u_fp_adder (.a(s1_a), .b(s1_b), .sum(sum));

    assign s2_free = !resp_valid || resp_ready;
    assign s1_load = !s1_valid || s2_free;
    assign s1_adv  = s1_valid && s2_free;
    assign accept  = |req_ready;
    assign busy    = s1_valid || resp_valid;

    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N_REQ))
                idx = idx - (ID_W+1)'(N_REQ);
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                win_id = idx[ID_W-1:0];
            end
        end
    end

    // rst_n gating keeps grants off during the asynchronous reset window
    always_comb begin
        req_ready = '0;
        if (found && s1_load && rst_n)
            req_ready = N_REQ'(1) << win_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_id      <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            rr_ptr     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            ops_done   <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_id    <= win_id;
                s1_a     <= req_a[win_id*32 +: 32];
                s1_b     <= req_b[win_id*32 +: 32];
                rr_ptr   <= (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s1_adv) begin
                resp_valid <= 1'b1;
                resp_id    <= s1_id;
                resp_data  <= sum;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
            if (resp_valid && resp_ready)
                ops_done <= ops_done + 32'd1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_add_arbiter
// Brief    : Directed vector table plus hand sequences for fp_add_arbiter.
// Revision : 1.0
// ============================================================================
module tb_fp_add_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid, req_ready;
    logic [127:0] req_a, req_b;
    logic         resp_valid, resp_ready;
    logic [1:0]   resp_id;
    logic [31:0]  resp_data, ops_done;
    logic         busy;

    fp_add_arbiter #(.N_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] id; logic [31:0] data; } exp_t;
    typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [31:0] s; } vec_t;

    exp_t        q[$];
    vec_t        vt[12];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_ops = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    endtask

    task automatic push(input int id, input logic [31:0] d);
        exp_t e;
        e.id   = 2'(id);
        e.data = d;
        q.push_back(e);
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
    endtask

    // one clock; any response handshake at this edge is checked against the queue
    task automatic tick();
        logic        hs;
        logic [1:0]  id;
        logic [31:0] d;
        exp_t        e;
        #1;
        hs = resp_valid && resp_ready;
        id = resp_id;
        d  = resp_data;
        @(posedge clk);
        #1;
        if (hs) begin
            exp_ops++;
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL resp_extra: got id %0d data 0x%08h, required no response", id, d);
            end else begin
                e = q.pop_front();
                check("resp_order_id", 32'(id), 32'(e.id));
                check("resp_order_data", d, e.data);
            end
        end
    endtask

    task automatic single_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
        req_valid = 4'(1 << id);
        set_req(id, a, b);
        #1;
        check("grant_single", 32'(req_ready), 32'(1 << id));
        push(id, s);
        tick();
        req_valid = 4'b0000;
        check("latency_not_yet", 32'(resp_valid), 32'd0);
        tick();
        check("latency_resp_valid", 32'(resp_valid), 32'd1);
        check("single_resp_data", resp_data, s);
        check("single_resp_id", 32'(resp_id), 32'(id));
        tick();
        check("single_ops_done", ops_done, exp_ops);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q.size() != 0 || busy); i++) tick();
        check("drain_queue_empty", 32'(q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_ops_done", ops_done, exp_ops);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        q.delete();
        exp_ops = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000}; // 1 + 2 = 3
        vt[1]  = '{1, 32'h4040_0000, 32'h4080_0000, 32'h40E0_0000}; // 3 + 4 = 7
        vt[2]  = '{2, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000}; // 1 + 1 = 2
        vt[3]  = '{3, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000}; // 1 - 1 = +0
        vt[4]  = '{1, 32'h40A0_0000, 32'hC040_0000, 32'h4000_0000}; // 5 - 3 = 2
        vt[5]  = '{2, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000}; // tie rounds to even
        vt[6]  = '{3, 32'h3F80_0000, 32'h3400_0000, 32'h3F80_0001}; // 1 + ulp
        vt[7]  = '{0, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000}; // inf + 1
        vt[8]  = '{1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000}; // overflow
        vt[9]  = '{2, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002}; // denormals
        vt[10] = '{3, 32'hC000_0000, 32'h3F80_0000, 32'hBF80_0000}; // -2 + 1 = -1
        vt[11] = '{0, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000}; // 1.5 + 1.5 = 3

        // reset state, with requests pending to show grants are suppressed
        rst_n      = 1'b0;
        req_valid  = 4'hF;
        req_a      = '1;
        req_b      = '1;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ops_done", ops_done, 32'd0);
        check("reset_resp_id", 32'(resp_id), 32'd0);
        check("reset_resp_data", resp_data, 32'd0);
        req_valid = 4'b0000;
        req_a     = '0;
        req_b     = '0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) single_op(vt[i].id, vt[i].a, vt[i].b, vt[i].s);

        // round-robin fairness from a freshly reset pointer
        do_reset();
        for (int r = 0; r < 4; r++) set_req(r, 32'h4040_0000, 32'h4080_0000);
        req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
            push(c % 4, 32'h40E0_0000);
            tick();
        end
        req_valid = 4'b0000;
        drain();

        // pointer wrap: grant 3 then requesters 1 and 3 compete
        single_op(3, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        set_req(1, 32'h4000_0000, 32'h4000_0000);
        set_req(3, 32'h4040_0000, 32'h4040_0000);
        req_valid = 4'b1010;
        #1;
        check("wrap_grant_first", 32'(req_ready), 32'h2);
        push(1, 32'h4080_0000);
        tick();
        #1;
        check("wrap_grant_second", 32'(req_ready), 32'h8);
        push(3, 32'h40C0_0000);
        tick();
        req_valid = 4'b0000;
        drain();

        // backpressure on a stream from requester 2
        set_req(2, 32'h3F80_0000, 32'h3F80_0000);
        req_valid = 4'b0100;
        #1;
        check("bp_grant_first", 32'(req_ready), 32'h4);
        push(2, 32'h4000_0000);
        tick();
        req_valid = 4'b0000;
        tick();
        resp_ready = 1'b0;
        set_req(2, 32'h4000_0000, 32'h3F80_0000);
        req_valid = 4'b0100;
        #1;
        check("bp_grant_extra", 32'(req_ready), 32'h4);
        push(2, 32'h4040_0000);
        tick();
        set_req(2, 32'h4040_0000, 32'h3F80_0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_no_grant", 32'(req_ready), 32'd0);
            check("bp_hold_data", resp_data, 32'h4000_0000);
            check("bp_hold_id", 32'(resp_id), 32'd2);
            check("bp_hold_valid", 32'(resp_valid), 32'd1);
            check("bp_ops_frozen", ops_done, exp_ops);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check("bp_grant_resume", 32'(req_ready), 32'h4);
        push(2, 32'h4080_0000);
        tick();
        set_req(2, 32'h4080_0000, 32'h3F80_0000);
        #1;
        check("bp_grant_next", 32'(req_ready), 32'h4);
        push(2, 32'h40A0_0000);
        tick();
        req_valid = 4'b0000;
        drain();

        // asynchronous reset with both stages full
        resp_ready = 1'b0;
        set_req(0, 32'h3F80_0000, 32'h3F80_0000);
        req_valid = 4'b0001;
        #1;
        check("midrst_grant", 32'(req_ready), 32'h1);
        tick();
        tick();
        check("midrst_pre_busy", 32'(busy), 32'd1);
        check("midrst_pre_resp_valid", 32'(resp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_ops_done", ops_done, 32'd0);
        q.delete();
        exp_ops   = 32'd0;
        req_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        single_op(0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);

        // idle: nothing moves, pointer still just past requester 0
        for (int i = 0; i < 10; i++) begin
            #1;
            check("idle_req_ready", 32'(req_ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ops_done", ops_done, exp_ops);
            tick();
        end
        set_req(0, 32'h3F80_0000, 32'h4000_0000);
        set_req(1, 32'h4000_0000, 32'h4000_0000);
        req_valid = 4'b0011;
        #1;
        check("idle_ptr_grant_1", 32'(req_ready), 32'h2);
        push(1, 32'h4080_0000);
        tick();
        #1;
        check("idle_ptr_grant_0", 32'(req_ready), 32'h1);
        push(0, 32'h4040_0000);
        tick();
        req_valid = 4'b0000;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
